// File: rtl/mfcc_buf_ctrl_pkg.sv
// Shared constants, FSM encoding and the play-word layout for the MFCC coefficient buffer.
package mfcc_buf_ctrl_pkg;

  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned DATA_W     = 14;
  localparam int unsigned NCOEF      = 13;
  localparam int unsigned MAX_FRAMES = 630;
  localparam int unsigned FCNT_W     = 10;
  localparam int unsigned COEF_W     = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRec  = 2'd1,
    StPlay = 2'd2
  } state_e;

  typedef struct packed {
    logic              last;
    logic [COEF_W-1:0] coef;
    logic [DATA_W-1:0] data;
  } play_word_t;

endpackage

// File: rtl/mfcc_rd_skid.sv
// Two-entry valid/ready buffer between the synchronous RAM read port and the matcher.
module mfcc_rd_skid
  import mfcc_buf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  play_word_t push_word,
  input  logic       out_ready,
  output logic       out_valid,
  output play_word_t out_word,
  output logic [1:0] occupancy
);

  play_word_t ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d, wr_idx;
  logic       pop;

  always_comb begin
    pop    = (cnt_q != 2'd0) && out_ready;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    wr_idx = cnt_q;
    if (pop) begin
      ent0_d = ent1_q;
      ent1_d = '0;
      cnt_d  = cnt_q - 2'd1;
      wr_idx = cnt_q - 2'd1;
    end
    // The issue logic never pushes into a full buffer; guard anyway.
    if (push && (wr_idx != 2'd2)) begin
      if (wr_idx == 2'd0) begin
        ent0_d = push_word;
      end else begin
        ent1_d = push_word;
      end
      cnt_d = wr_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_word  = ent0_q;
  assign occupancy = cnt_q;

endmodule

// File: rtl/mfcc_buf_ctrl.sv
// Record/play sequencer for the 8192x14 MFCC coefficient SDP RAM.
module mfcc_buf_ctrl
  import mfcc_buf_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_start,
  input  logic              rec_end,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              rd_start,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [COEF_W-1:0] out_coef,
  output logic              out_last,
  input  logic              out_ready,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy,
  output logic              overflow,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);

  state_e            state_q;
  logic [COEF_W-1:0] wr_coef_q, rd_coef_q, meta_coef_q;
  logic [ADDR_W-1:0] wr_base_q, rd_addr_q;
  logic [FCNT_W-1:0] frame_cnt_q, rd_frame_q;
  logic              overflow_q, rd_done_q, inflight_q, meta_last_q;

  logic       accept, play_start, pop, issue, last_issue;
  logic [1:0] occ;
  logic [2:0] pending;
  play_word_t push_word, out_word;

  always_comb begin
    in_ready    = (state_q == StRec) && (frame_cnt_q < FCNT_W'(MAX_FRAMES));
    accept      = in_valid && in_ready;
    ram_wr_en   = accept;
    ram_wr_addr = wr_base_q + {{(ADDR_W - COEF_W){1'b0}}, wr_coef_q};
    ram_wr_data = accept ? in_data : '0;
    play_start  = (state_q == StIdle) && rd_start && !rec_start && (frame_cnt_q != '0);
    pop         = out_valid && out_ready;
    // Words that will be buffered or in flight after this edge, counting the pop.
    pending     = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    issue       = play_start || ((state_q == StPlay) && !rd_done_q && (pending < 3'd2));
    last_issue  = (rd_frame_q == frame_cnt_q - FCNT_W'(1)) &&
                  (rd_coef_q == COEF_W'(NCOEF - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_coef_q   <= '0;
      wr_base_q   <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_coef_q   <= '0;
      rd_frame_q  <= '0;
      rd_done_q   <= 1'b0;
      inflight_q  <= 1'b0;
      meta_coef_q <= '0;
      meta_last_q <= 1'b0;
    end else begin
      inflight_q  <= issue;
      meta_coef_q <= rd_coef_q;
      meta_last_q <= last_issue;
      if (issue) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
        if (rd_coef_q == COEF_W'(NCOEF - 1)) begin
          rd_coef_q  <= '0;
          rd_frame_q <= rd_frame_q + FCNT_W'(1);
        end else begin
          rd_coef_q <= rd_coef_q + COEF_W'(1);
        end
        if (last_issue) begin
          rd_done_q <= 1'b1;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (rec_start) begin
            state_q     <= StRec;
            wr_coef_q   <= '0;
            wr_base_q   <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
          end else if (play_start) begin
            state_q <= StPlay;
          end
        end
        StRec: begin
          if (accept) begin
            if (wr_coef_q == COEF_W'(NCOEF - 1)) begin
              wr_coef_q   <= '0;
              wr_base_q   <= wr_base_q + ADDR_W'(NCOEF);
              frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
            end else begin
              wr_coef_q <= wr_coef_q + COEF_W'(1);
            end
          end
          if (in_valid && (frame_cnt_q == FCNT_W'(MAX_FRAMES))) begin
            overflow_q <= 1'b1;
          end
          // A partial frame is dropped by rewinding the coefficient index.
          if (rec_end) begin
            state_q   <= StIdle;
            wr_coef_q <= '0;
          end
        end
        StPlay: begin
          if (pop && out_word.last) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            rd_coef_q  <= '0;
            rd_frame_q <= '0;
            rd_done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign push_word = '{last: meta_last_q, coef: meta_coef_q, data: ram_rd_data};

  mfcc_rd_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_word (push_word),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .occupancy (occ)
  );

  assign out_data    = out_word.data;
  assign out_coef    = out_word.coef;
  assign out_last    = out_word.last;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = (state_q != StIdle);
  assign overflow    = overflow_q;
  assign ram_rd_addr = rd_addr_q;

endmodule
